dla_cmd_issuer: RTL and testbench

Host-side initiator for the DLA control-register interface; the DLA top level is the responder. It accepts 128-bit layer descriptors from a command stream and buffers them in a small FIFO. For each descriptor it writes mapping_param, shape_param1, shape_param2 and op_config (start bit forced high), waits for dla_done, then writes op_config with the start bit cleared and waits for dla_done to drop. It sits between the testbench/host sequencer and the DLA top, so whole networks run without per-layer software handshaking.

---
 rtl/dla_ctrl_pkg.sv | 47 ++++
 rtl/cmd_fifo.sv | 51 +++++
 rtl/dla_cmd_issuer.sv | 166 ++++++++++++++++
 tb/tb_dla_cmd_issuer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_ctrl_pkg.sv
// dla_ctrl_pkg: shared definitions for the DLA command issuer.
//   - write-select codes for the DLA control-register interface
//   - issuer FSM state encoding
//   - 128-bit layer descriptor layout (field offsets + packed struct view)
package dla_ctrl_pkg;

    // Control-register write selects
    localparam logic [1:0] WSEL_MAP   = 2'd0;
    localparam logic [1:0] WSEL_SH1   = 2'd1;
    localparam logic [1:0] WSEL_SH2   = 2'd2;
    localparam logic [1:0] WSEL_OPCFG = 2'd3;

    // Descriptor field layout
    localparam int DESC_W    = 128;
    localparam int FIELD_W   = 32;
    localparam int MAP_LSB   = 0;
    localparam int SH1_LSB   = 32;
    localparam int SH2_LSB   = 64;
    localparam int OPCFG_LSB = 96;

    // Packed view of a descriptor; member order (MSB first) matches the
    // field offsets above so a plain cast from the command word works.
    typedef struct packed {
        logic [FIELD_W-1:0] op_config;
        logic [FIELD_W-1:0] shape_param2;
        logic [FIELD_W-1:0] shape_param1;
        logic [FIELD_W-1:0] mapping_param;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        W_MAP,
        W_SH1,
        W_SH2,
        W_START,
        WAIT_DONE,
        W_STOP,
        WAIT_IDLE
    } state_t;

    // Bit 0 of op_config is the DLA start bit.
    function automatic logic [FIELD_W-1:0] op_with_start(input logic [FIELD_W-1:0] op,
                                                         input logic start);
        return {op[FIELD_W-1:1], start};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous single-clock FIFO for layer descriptors.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request; ignored while full
//   pop/rdata  : read request; rdata is the current head (valid when !empty)
//   full/empty : status flags
// Pointers carry one extra wrap bit so full and empty stay distinct when the
// address bits coincide.
module cmd_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dla_cmd_issuer.sv
// dla_cmd_issuer: host-side sequencer that drives the DLA control registers
// from a queue of 128-bit layer descriptors.
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/ready/data     : descriptor stream into the internal FIFO
//   ctrl_reg_w_en/wsel/wdata : DLA control-register write port
//   dla_done                 : DLA done level
//   busy                     : FSM active or descriptors queued
//   layer_done               : one-cycle pulse when a layer retires
//   layers_done              : wrapping count of retired layers
//   err_timeout, err_clr     : sticky WAIT_DONE timeout flag and its clear
// Per layer: map, shape1, shape2, op_config with start set, wait for done,
// op_config with start cleared, wait for done to drop.
module dla_cmd_issuer
    import dla_ctrl_pkg::*;
#(
    parameter int          CMD_DEPTH      = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [127:0]     cmd_data,
    output logic             ctrl_reg_w_en,
    output logic [1:0]       ctrl_reg_wsel,
    output logic [31:0]      ctrl_reg_wdata,
    input  logic             dla_done,
    output logic             busy,
    output logic             layer_done,
    output logic [CNT_W-1:0] layers_done,
    output logic             err_timeout,
    input  logic             err_clr
);

    state_t       state, state_n;
    desc_t        desc;
    logic [127:0] fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [31:0]  to_cnt;
    logic         to_hit;

    // No pass-through: a full FIFO refuses even when a pop is happening.
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;

    cmd_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (cmd_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n        = state;
        ctrl_reg_w_en  = 1'b0;
        ctrl_reg_wsel  = WSEL_MAP;
        ctrl_reg_wdata = '0;
        to_hit         = 1'b0;
        layer_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) state_n = W_MAP;
            end
            W_MAP: begin
                ctrl_reg_w_en  = 1'b1;
                ctrl_reg_wsel  = WSEL_MAP;
                ctrl_reg_wdata = desc.mapping_param;
                state_n        = W_SH1;
            end
            W_SH1: begin
                ctrl_reg_w_en  = 1'b1;
                ctrl_reg_wsel  = WSEL_SH1;
                ctrl_reg_wdata = desc.shape_param1;
                state_n        = W_SH2;
            end
            W_SH2: begin
                ctrl_reg_w_en  = 1'b1;
                ctrl_reg_wsel  = WSEL_SH2;
                ctrl_reg_wdata = desc.shape_param2;
                state_n        = W_START;
            end
            W_START: begin
                ctrl_reg_w_en  = 1'b1;
                ctrl_reg_wsel  = WSEL_OPCFG;
                ctrl_reg_wdata = op_with_start(desc.op_config, 1'b1);
                state_n        = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done is checked first so it beats a coincident timeout
                if (dla_done) begin
                    state_n = W_STOP;
                end else if ((TIMEOUT_CYCLES != 32'd0) &&
                             (to_cnt == TIMEOUT_CYCLES - 32'd1)) begin
                    to_hit  = 1'b1;
                    state_n = W_STOP;
                end
            end
            W_STOP: begin
                ctrl_reg_w_en  = 1'b1;
                ctrl_reg_wsel  = WSEL_OPCFG;
                ctrl_reg_wdata = op_with_start(desc.op_config, 1'b0);
                state_n        = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!dla_done) begin
                    layer_done = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) desc <= desc_t'(fifo_head);
    end

    // Cycles spent in WAIT_DONE; cleared whenever the state is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state == WAIT_DONE) && (state_n == WAIT_DONE)) begin
            to_cnt <= to_cnt + 32'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (to_hit) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layers_done <= '0;
        end else if (layer_done) begin
            layers_done <= layers_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dla_cmd_issuer.sv
// Scoreboard bench for dla_cmd_issuer. Each accepted descriptor queues its
// five expected register writes; a monitor pops them as writes appear. A
// small DLA responder raises dla_done after a per-layer delay (0 = never,
// forcing the timeout path) and drops it a few cycles after the stop write.
module tb_dla_cmd_issuer;

    localparam int CW     = 4;
    localparam int TO     = 20;
    localparam int NRAND  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [127:0]  cmd_data = '0;
    logic          ctrl_reg_w_en;
    logic [1:0]    ctrl_reg_wsel;
    logic [31:0]   ctrl_reg_wdata;
    logic          dla_done = 1'b0;
    logic          busy;
    logic          layer_done;
    logic [CW-1:0] layers_done;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    dla_cmd_issuer #(
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .ctrl_reg_w_en  (ctrl_reg_w_en),
        .ctrl_reg_wsel  (ctrl_reg_wsel),
        .ctrl_reg_wdata (ctrl_reg_wdata),
        .dla_done       (dla_done),
        .busy           (busy),
        .layer_done     (layer_done),
        .layers_done    (layers_done),
        .err_timeout    (err_timeout),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  delay_q[$];
    int  compared = 0;
    int  mismatched = 0;

    // shared bench state
    int  acc_cyc = 0;
    bit  first_chk = 0;
    int  starts = 0;
    int  pulses = 0;
    int  exp_layers = 0;
    bit  exp_err = 0;
    int  cur_delay = 0;
    bit  cur_to = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- DLA responder ----------------
    initial begin : responder
        bit armed = 0;
        int rcnt = 0;
        int low_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                armed = 0;
                low_cnt = 0;
                dla_done = 1'b0;
            end else begin
                if (armed) begin
                    rcnt++;
                    if (cur_delay != 0 && rcnt == cur_delay) dla_done = 1'b1;
                end else if (low_cnt > 0) begin
                    low_cnt--;
                    if (low_cnt == 0) dla_done = 1'b0;
                end
                if (ctrl_reg_w_en && ctrl_reg_wsel == 2'd3 && ctrl_reg_wdata[0]) begin
                    armed = 1;
                    rcnt = 0;
                    cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                    cur_to = (cur_delay == 0);
                end else if (ctrl_reg_w_en && ctrl_reg_wsel == 2'd3 && armed) begin
                    armed = 0;
                    low_cnt = $urandom_range(0, 3);
                    if (low_cnt == 0) dla_done = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit in_wd = 0;
        bit stop_seen = 0;
        int wd_cnt = 0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_layers = 0;
                exp_err = 0;
                pulses = 0;
                in_wd = 0;
                stop_seen = 0;
            end else begin
                if (in_wd) wd_cnt++;
                if (ctrl_reg_w_en) begin
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_write sel=%0d data=%0h", ctrl_reg_wsel, ctrl_reg_wdata));
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_sel", 64'(ctrl_reg_wsel), 64'(e.sel));
                        check("wr_data", 64'(ctrl_reg_wdata), 64'(e.data));
                    end
                    if (first_chk) begin
                        check("first_write_latency", 64'(cyc - acc_cyc), 64'd2);
                        first_chk = 0;
                    end
                    if (ctrl_reg_wsel == 2'd3 && ctrl_reg_wdata[0]) begin
                        in_wd = 1;
                        wd_cnt = 0;
                        starts++;
                    end else if (ctrl_reg_wsel == 2'd3 && in_wd) begin
                        in_wd = 0;
                        // done seen in WAIT_DONE cycle d -> stop write d+1 cycles after start
                        check("stop_latency", 64'(wd_cnt), cur_to ? 64'(TO + 1) : 64'(cur_delay + 1));
                        if (cur_to) exp_err = 1;
                        check("err_at_stop", 64'(err_timeout), 64'(exp_err));
                        stop_seen = 1;
                    end
                end
                if (layer_done) begin
                    check("layer_done_after_stop", 64'(stop_seen), 64'd1);
                    stop_seen = 0;
                    check("layers_done_count", 64'(layers_done), 64'(exp_layers));
                    exp_layers = (exp_layers + 1) % (1 << CW);
                    pulses++;
                end
                if (err_clr) exp_err = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [31:0] m, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] op, input int dly);
        bit acc = 0;
        cmd_data  = {op, s2, s1, m};
        cmd_valid = 1'b1;
        for (int t = 0; t < 5000 && !acc; t++) begin
            if (cmd_ready) begin
                acc = 1;
                acc_cyc = cyc;
                exp_q.push_back('{2'd0, m});
                exp_q.push_back('{2'd1, s1});
                exp_q.push_back('{2'd2, s2});
                exp_q.push_back('{2'd3, op | 32'd1});
                exp_q.push_back('{2'd3, op & ~32'd1});
                delay_q.push_back(dly);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!acc) fail_now("push_timeout");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !dla_done) ok = 1;
        end
        if (!ok) fail_now("wait_idle_timeout");
    endtask

    task automatic rand_push(input int dly);
        push($urandom, $urandom, $urandom, $urandom, dly);
    endtask

    initial begin : stim
        int s0;
        bit ok;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_outputs", {ctrl_reg_w_en, ctrl_reg_wsel, ctrl_reg_wdata, busy, layer_done,
                                layers_done, err_timeout}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single descriptor, latency of first write
        first_chk = 1;
        push(32'h1249, 32'h05500000, 32'h0808, 32'h401, 15);
        wait_idle();
        check("layers_after_one", 64'(layers_done), 64'd1);

        // op_config with start bit low
        push(32'h1, 32'h2, 32'h3, 32'h0400, 5);
        wait_idle();

        // timeout path, then clear
        push(32'hA, 32'hB, 32'hC, 32'h0D00, 0);
        wait_idle();
        check("err_sticky", 64'(err_timeout), 64'd1);
        err_clr = 1'b1;
        repeat (2) @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 64'(err_timeout), 64'd0);
        check("layers_after_three", 64'(layers_done), 64'd3);

        // burst of 5 while the DLA is slow: FIFO fills behind the active layer
        s0 = starts;
        rand_push(15);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (starts != s0) ok = 1;
        end
        if (!ok) fail_now("burst_start_timeout");
        for (int i = 0; i < 4; i++) rand_push($urandom_range(1, 15));
        check("burst_full_ready", 64'(cmd_ready), 64'd0);
        check("burst_full_busy", 64'(busy), 64'd1);
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        check("burst_ready_returns", 64'(ok), 64'd1);
        wait_idle();
        check("layers_after_burst", 64'(layers_done), 64'd8);

        // reset during WAIT_DONE with two descriptors queued
        s0 = starts;
        rand_push(0);
        rand_push(4);
        rand_push(4);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (starts != s0) ok = 1;
        end
        if (!ok) fail_now("reset_test_start_timeout");
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        delay_q.delete();
        @(negedge clk);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_outputs", {ctrl_reg_w_en, ctrl_reg_wsel, ctrl_reg_wdata, busy, layer_done,
                                 layers_done, err_timeout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_reset_idle", 64'(busy), 64'd0);

        // randomized traffic; CW=4 so the counter wraps past 15
        for (int i = 0; i < NRAND; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rand_push(($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 15));
        end
        wait_idle();
        check("final_pulses", 64'(pulses), 64'(NRAND));
        check("final_layers_wrapped", 64'(layers_done), 64'(NRAND % (1 << CW)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
